// File: rtl/hc_pkg.sv
// Shared types for the host-channel buffer engines: line/request types,
// loopback transform modes and the loopback engine state encoding.
package hc_pkg;

    typedef logic [511:0] t_buffer_data;
    typedef logic [15:0]  t_request_size;
    typedef logic [2:0]   t_buffer_id;

    typedef enum logic [1:0] {
        LB_PASS = 2'd0,
        LB_INV  = 2'd1,
        LB_INC  = 2'd2
    } t_lb_mode;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY,
        DONE
    } t_lb_state;

    localparam int unsigned LANE_WIDTH = 32;

endpackage

// File: rtl/loopback_fifo.sv
// Line FIFO for the loopback engine; registered read data appears the cycle after deq_en.
module loopback_fifo #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_en,
    input  logic [WIDTH-1:0]         enq_data,
    input  logic                     deq_en,
    output logic [WIDTH-1:0]         deq_data,
    output logic                     not_full,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   counter
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (enq_en) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            counter  <= '0;
            deq_data <= '0;
        end else begin
            if (enq_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq_en) begin
                rd_ptr   <= rd_ptr + AW'(1);
                deq_data <= mem[rd_ptr];
            end
            case ({enq_en, deq_en})
                2'b10:   counter <= counter + CNTW'(1);
                2'b01:   counter <= counter - CNTW'(1);
                default: counter <= counter;
            endcase
        end
    end

    assign not_full  = (counter != CNTW'(DEPTH));
    assign not_empty = (counter != '0);

endmodule

// File: rtl/loopback_stream_engine.sv
// Streams num_lines lines from SRC_BUFFER to DST_BUFFER through a credit-throttled
// line FIFO, applying an optional per-line transform, and raises a sticky finish.
module loopback_stream_engine
    import hc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = $bits(t_buffer_data),
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter int unsigned CHUNK_LINES = 64,
    parameter int unsigned SRC_BUFFER  = 1,
    parameter int unsigned DST_BUFFER  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  t_request_size         num_lines,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  finish,
    output t_request_size         lines_done,
    output logic                  buffer_read_stream,
    output t_buffer_id            buffer_read_buffer,
    output t_request_size         buffer_read_len,
    input  logic                  buffer_valid,
    input  logic [DATA_WIDTH-1:0] buffer_data,
    output logic                  buffer_write_stream,
    output t_buffer_id            buffer_write_buffer,
    output logic [DATA_WIDTH-1:0] buffer_write_data,
    input  logic                  buffer_write_full
);

    localparam int unsigned   FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned   CW    = $bits(t_request_size) + 2;
    localparam int unsigned   LANES = DATA_WIDTH / LANE_WIDTH;
    localparam t_request_size ONE   = t_request_size'(1);
    localparam t_request_size CHUNK = t_request_size'(CHUNK_LINES);

    t_lb_state       state;
    t_request_size   num_q;
    logic [1:0]      mode_q;
    t_request_size   lines_req;
    t_request_size   lines_rcvd;
    t_request_size   lines_wr_issued;
    logic            rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic            wr_pending;

    logic            fifo_not_full;
    logic            fifo_not_empty;
    logic [FCW-1:0]  fifo_counter;
    logic [DATA_WIDTH-1:0] deq_data;
    logic [DATA_WIDTH-1:0] xform_data;

    t_request_size   remaining;
    t_request_size   req_len;
    logic [CW-1:0]   credit_sum;
    logic            can_req;
    logic            can_deq;

    // lines_rcvd advances at enqueue, so a beat parked in rx_data still counts as outstanding
    always_comb begin
        remaining  = num_q - lines_req;
        req_len    = (remaining > CHUNK) ? CHUNK : remaining;
        credit_sum = CW'(fifo_counter) + CW'(lines_req - lines_rcvd) + CW'(req_len);
        can_req    = (state == BUSY) && !buffer_read_stream && (lines_req < num_q)
                     && (credit_sum <= CW'(FIFO_DEPTH));
        can_deq    = (state == BUSY) && fifo_not_empty && !buffer_write_full
                     && (lines_wr_issued < num_q);
    end

    always_comb begin
        xform_data = deq_data;
        case (mode_q)
            LB_INV: xform_data = ~deq_data;
            LB_INC: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    xform_data[i*LANE_WIDTH +: LANE_WIDTH] =
                        deq_data[i*LANE_WIDTH +: LANE_WIDTH] + LANE_WIDTH'(1);
                end
            end
            default: xform_data = deq_data;
        endcase
    end

    assign buffer_write_stream = wr_pending;
    assign buffer_write_buffer = wr_pending ? t_buffer_id'(DST_BUFFER) : '0;
    assign buffer_write_data   = wr_pending ? xform_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            num_q              <= '0;
            mode_q             <= '0;
            lines_req          <= '0;
            lines_rcvd         <= '0;
            lines_wr_issued    <= '0;
            lines_done         <= '0;
            busy               <= 1'b0;
            finish             <= 1'b0;
            rx_valid           <= 1'b0;
            rx_data            <= '0;
            wr_pending         <= 1'b0;
            buffer_read_stream <= 1'b0;
            buffer_read_buffer <= '0;
            buffer_read_len    <= '0;
        end else begin
            buffer_read_stream <= 1'b0;
            buffer_read_buffer <= '0;
            buffer_read_len    <= '0;
            rx_valid           <= 1'b0;
            wr_pending         <= 1'b0;
            if (wr_pending) begin
                lines_done <= lines_done + ONE;
            end
            if (rx_valid) begin
                lines_rcvd <= lines_rcvd + ONE;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= LOAD;
                        num_q           <= num_lines;
                        mode_q          <= mode;
                        lines_req       <= '0;
                        lines_rcvd      <= '0;
                        lines_wr_issued <= '0;
                        lines_done      <= '0;
                        finish          <= 1'b0;
                        busy            <= 1'b1;
                    end
                end
                LOAD: begin
                    if (num_q == '0) begin
                        state  <= DONE;
                        finish <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (buffer_valid) begin
                        rx_valid <= 1'b1;
                        rx_data  <= buffer_data;
                    end
                    if (can_req) begin
                        buffer_read_stream <= 1'b1;
                        buffer_read_buffer <= t_buffer_id'(SRC_BUFFER);
                        buffer_read_len    <= req_len;
                        lines_req          <= lines_req + req_len;
                    end
                    if (can_deq) begin
                        lines_wr_issued <= lines_wr_issued + ONE;
                        wr_pending      <= 1'b1;
                    end
                    if (lines_done == num_q) begin
                        state  <= DONE;
                        finish <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    loopback_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_en    (rx_valid),
        .enq_data  (rx_data),
        .deq_en    (can_deq),
        .deq_data  (deq_data),
        .not_full  (fifo_not_full),
        .not_empty (fifo_not_empty),
        .counter   (fifo_counter)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(rx_valid && !fifo_not_full));

endmodule
